// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl -- UART transmit frame controller.
// Frames each byte as start bit, 8 data bits (LSB first), optional parity bit
// and stop bit. It drives the load and shift-enable inputs of an external
// 8-bit serializer and muxes the serializer output onto the TX line.
//
// Optional feature macro: UART_TX_HOLD_EN
//   defined   : one-byte hold buffer; frames can run back to back.
//   undefined : bytes accepted only in IDLE; frames are separated by idle.
//
// Byte handshake: a byte (P_DATA with PAR_EN/PAR_TYP) transfers on any rising
// CLK edge where DATA_VALID and READY are both high; DATA_VALID while READY is
// low is dropped with no side effect.
module uart_tx_ctrl (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] P_DATA,
  input  logic       DATA_VALID,
  input  logic       PAR_EN,
  input  logic       PAR_TYP,
  output logic       READY,
  output logic [7:0] SER_P_DATA,
  output logic       SER_LOAD,
  output logic       SER_EN,
  input  logic       SER_DONE,
  input  logic       SER_DATA,
  output logic       TX_OUT,
  output logic       BUSY,
  output logic       FRAME_DONE
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t     r_state;
  state_t     w_next_state;

  logic       r_par_bit;     // parity bit of the frame in flight
  logic       r_par_en;      // parity cycle enabled for the frame in flight

  logic       w_ready;
  logic       w_accept;      // byte handshake completes this cycle
  logic       w_load;        // serializer is loaded this cycle
  logic [7:0] w_ld_data;     // byte loaded into the serializer
  logic       w_ld_par_en;
  logic       w_ld_par_typ;

  assign w_accept = DATA_VALID & w_ready;

`ifdef UART_TX_HOLD_EN
  logic       r_hold_full;
  logic [7:0] r_hold_data;
  logic       r_hold_par_en;
  logic       r_hold_par_typ;
  logic       w_load_hold;   // drain the hold buffer into the serializer
  logic       w_load_direct; // load the serializer straight from P_DATA
  logic       w_fill;        // accepted byte goes into the hold buffer

  // STOP is always ready: either the buffer is empty, or it drains this cycle.
  assign w_ready       = (r_state == S_IDLE) | (r_state == S_STOP) | ~r_hold_full;
  assign w_load_hold   = (r_state == S_STOP) & r_hold_full;
  assign w_load_direct = w_accept &
                         ((r_state == S_IDLE) | ((r_state == S_STOP) & ~r_hold_full));
  assign w_fill        = w_accept & ~w_load_direct;
  assign w_load        = w_load_hold | w_load_direct;
  assign w_ld_data     = w_load_hold ? r_hold_data    : P_DATA;
  assign w_ld_par_en   = w_load_hold ? r_hold_par_en  : PAR_EN;
  assign w_ld_par_typ  = w_load_hold ? r_hold_par_typ : PAR_TYP;

  // Hold buffer: a refill in the drain cycle wins over the drain.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_hold_full    <= 1'b0;
      r_hold_data    <= 8'h00;
      r_hold_par_en  <= 1'b0;
      r_hold_par_typ <= 1'b0;
    end else if (w_fill) begin
      r_hold_full    <= 1'b1;
      r_hold_data    <= P_DATA;
      r_hold_par_en  <= PAR_EN;
      r_hold_par_typ <= PAR_TYP;
    end else if (w_load_hold) begin
      r_hold_full    <= 1'b0;
    end
  end
`else
  assign w_ready      = (r_state == S_IDLE);
  assign w_load       = w_accept;
  assign w_ld_data    = P_DATA;
  assign w_ld_par_en  = PAR_EN;
  assign w_ld_par_typ = PAR_TYP;
`endif

  assign READY = w_ready;

  // Latch parity settings with the byte so mid-frame input changes are ignored.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_par_bit <= 1'b0;
      r_par_en  <= 1'b0;
    end else if (w_load) begin
      r_par_bit <= w_ld_par_typ ? ~^w_ld_data : ^w_ld_data;
      r_par_en  <= w_ld_par_en;
    end
  end

  // State register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (w_load) w_next_state = S_START;
      S_START:  w_next_state = S_DATA;
      S_DATA:   if (SER_DONE) w_next_state = r_par_en ? S_PARITY : S_STOP;
      S_PARITY: w_next_state = S_STOP;
      S_STOP:   w_next_state = w_load ? S_START : S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output decode: line mux, shift enable, status, serializer load.
  always_comb begin
    TX_OUT     = 1'b1;
    SER_EN     = 1'b0;
    BUSY       = 1'b0;
    FRAME_DONE = 1'b0;
    SER_LOAD   = w_load;
    SER_P_DATA = w_load ? w_ld_data : 8'h00;
    case (r_state)
      S_IDLE: begin
        TX_OUT = 1'b1;
      end
      S_START: begin
        TX_OUT = 1'b0;
        SER_EN = 1'b1;
        BUSY   = 1'b1;
      end
      S_DATA: begin
        TX_OUT = SER_DATA;
        SER_EN = ~SER_DONE;
        BUSY   = 1'b1;
      end
      S_PARITY: begin
        TX_OUT = r_par_bit;
        BUSY   = 1'b1;
      end
      S_STOP: begin
        TX_OUT     = 1'b1;
        BUSY       = 1'b1;
        FRAME_DONE = 1'b1;
      end
      default: begin
        TX_OUT = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl -- directed bench for uart_tx_ctrl with a behavioural
// 8-bit LSB-first serializer and an expected-line-bit queue.
module tb_uart_tx_ctrl;

  // ---------------- clock / reset ----------------
  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       READY;
  logic [7:0] SER_P_DATA;
  logic       SER_LOAD;
  logic       SER_EN;
  logic       SER_DONE;
  logic       SER_DATA;
  logic       TX_OUT;
  logic       BUSY;
  logic       FRAME_DONE;

  always #5 CLK = ~CLK;

  uart_tx_ctrl dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .READY      (READY),
    .SER_P_DATA (SER_P_DATA),
    .SER_LOAD   (SER_LOAD),
    .SER_EN     (SER_EN),
    .SER_DONE   (SER_DONE),
    .SER_DATA   (SER_DATA),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .FRAME_DONE (FRAME_DONE)
  );

  // ---------------- serializer model ----------------
  logic [7:0] ser_sh;
  logic [3:0] ser_cnt;
  logic       ser_q;

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ser_sh  <= 8'h00;
      ser_cnt <= 4'd0;
      ser_q   <= 1'b0;
    end else if (SER_LOAD) begin
      ser_sh  <= SER_P_DATA;
      ser_cnt <= 4'd0;
    end else if (SER_EN) begin
      ser_q   <= ser_sh[0];
      ser_sh  <= {1'b0, ser_sh[7:1]};
      ser_cnt <= ser_cnt + 4'd1;
    end
  end

  assign SER_DATA = ser_q;
  assign SER_DONE = (ser_cnt == 4'd8);

  // ---------------- scoreboard ----------------
  // Each entry: {frame_done, tx_bit} expected for one busy cycle.
  logic [1:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;
  int en_cnt   = 0;
  bit b2b      = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // seq holds the line bits in time order starting at seq[10].
  task automatic push_frame(input logic [10:0] seq, input int len);
    logic [1:0] e;
    for (int i = 0; i < len; i++) begin
      e = {(i == len - 1) ? 1'b1 : 1'b0, seq[10 - i]};
      exp_q.push_back(e);
    end
  endtask

  // Line monitor, sampled on the falling edge.
  always @(negedge CLK) begin
    logic [1:0] e;
    if (RST) begin
      en_cnt = 0;
      b2b    = 1'b0;
    end else begin
      if (b2b) check("b2b_busy", BUSY, 1);
      b2b = 1'b0;
      if (BUSY) begin
        if (SER_EN) en_cnt++;
        if (!FRAME_DONE) check("ser_load_mid", SER_LOAD, 0);
        if (exp_q.size() == 0) begin
          check("extra_busy", BUSY, 0);
        end else begin
          e = exp_q.pop_front();
          check("tx_bit", TX_OUT, e[0]);
          check("frame_done", FRAME_DONE, e[1]);
          if (e[1]) begin
            check("ser_en_cnt", en_cnt, 8);
            en_cnt = 0;
            if (exp_q.size() != 0) b2b = 1'b1;
          end
        end
      end else begin
        check("idle_tx", TX_OUT, 1);
        check("idle_ser_en", SER_EN, 0);
        check("idle_done", FRAME_DONE, 0);
        if (!DATA_VALID) check("idle_load", SER_LOAD, 0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_byte(input logic [7:0] d, input logic pe, input logic pt,
                           input logic exp_ready, input logic exp_load);
    @(posedge CLK); #2;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    DATA_VALID = 1'b1;
    #1;
    check("ready", READY, exp_ready);
    check("ser_load", SER_LOAD, exp_load);
    if (exp_load) check("ser_p_data", SER_P_DATA, d);
    @(posedge CLK); #2;
    DATA_VALID = 1'b0;
    PAR_EN     = ~pe;   // later changes must not affect the frame
    PAR_TYP    = ~pt;
  endtask

  task automatic wait_idle();
    for (int k = 0; k < 60; k++) begin
      @(posedge CLK); #3;
      if (exp_q.size() == 0 && !BUSY) break;
    end
    check("drain_q", exp_q.size(), 0);
    check("idle_busy", BUSY, 0);
  endtask

  task automatic idle_cycles(input int n);
    for (int k = 0; k < n; k++) @(posedge CLK);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    RST = 1'b0; P_DATA = 8'h00; DATA_VALID = 1'b0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    #3 RST = 1'b1;
    idle_cycles(2);
    #1;
    check("rst_tx", TX_OUT, 1);
    check("rst_ready", READY, 1);
    check("rst_busy", BUSY, 0);
    check("rst_load", SER_LOAD, 0);
    check("rst_en", SER_EN, 0);
    check("rst_done", FRAME_DONE, 0);
    check("rst_p_data", SER_P_DATA, 8'h00);
    @(posedge CLK); #3 RST = 1'b0;
    idle_cycles(5);

    // 0xA5 even parity
    push_frame(11'b01010010101, 11);
    send_byte(8'hA5, 1'b1, 1'b0, 1'b1, 1'b1);
    #1;
    check("latency_busy", BUSY, 1);
    check("latency_start", TX_OUT, 0);
    wait_idle();

    // 0xA5 odd parity
    push_frame(11'b01010010111, 11);
    send_byte(8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    wait_idle();

    // 0xA5 without parity
    push_frame(11'b01010010110, 10);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    wait_idle();

    // 0x3C with 0xFF offered during the data bits
    push_frame(11'b00011110010, 10);
`ifdef UART_TX_HOLD_EN
    push_frame(11'b01111111110, 10);
`endif
    send_byte(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(2);
`ifdef UART_TX_HOLD_EN
    send_byte(8'hFF, 1'b0, 1'b0, 1'b1, 1'b0);
`else
    send_byte(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    wait_idle();
    idle_cycles(4);

    // Reset during data bit 3 (value 0 for 0xA5)
    push_frame(11'b01010010110, 10);
    send_byte(8'hA5, 1'b0, 1'b0, 1'b1, 1'b1);
    idle_cycles(4);
    #3;
    check("pre_rst_bit3", TX_OUT, 0);
    RST = 1'b1;
    #1;
    check("mid_rst_tx", TX_OUT, 1);
    check("mid_rst_busy", BUSY, 0);
    check("mid_rst_ready", READY, 1);
    check("mid_rst_en", SER_EN, 0);
    exp_q.delete();
    @(posedge CLK); #3 RST = 1'b0;
    idle_cycles(3);

    // 0x81 even parity after reset
    push_frame(11'b01000000101, 11);
    send_byte(8'h81, 1'b1, 1'b0, 1'b1, 1'b1);
    wait_idle();

`ifdef UART_TX_HOLD_EN
    // Three bytes: 0x03 first offered while the buffer is full
    push_frame(11'b01000000010, 10);
    push_frame(11'b00100000010, 10);
    push_frame(11'b01100000010, 10);
    send_byte(8'h01, 1'b0, 1'b0, 1'b1, 1'b1);
    send_byte(8'h02, 1'b0, 1'b0, 1'b1, 1'b0);
    send_byte(8'h03, 1'b0, 1'b0, 1'b0, 1'b0);
    begin
      bit got_ready;
      got_ready = 1'b0;
      for (int k = 0; k < 30; k++) begin
        @(posedge CLK); #2;
        if (READY) begin
          got_ready = 1'b1;
          break;
        end
      end
      check("hold_ready_wait", got_ready, 1);
      check("drain_frame_done", FRAME_DONE, 1);
      check("drain_load", SER_LOAD, 1);
      check("drain_p_data", SER_P_DATA, 8'h01 + 8'h01);
      P_DATA = 8'h03; PAR_EN = 1'b0; PAR_TYP = 1'b0; DATA_VALID = 1'b1;
      @(posedge CLK); #2;
      DATA_VALID = 1'b0;
    end
    wait_idle();
`endif

    idle_cycles(3);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded 200000 time units, %0d/%0d checks passed",
             n_pass, n_checks);
    $fatal(1);
  end

endmodule
